// File: rtl/exception_ctrl.sv
// Exception/interrupt responder: latches ERR/ESR, pulses exc/eret_taken, acks IRQs.
// Optional saturating exception counter enabled by defining EXC_COUNTER_EN.
module exception_ctrl #(
    parameter int             N          = 64,
    parameter logic [N-1:0]   EXC_VECTOR = N'(64'h0000_0000_0000_00D8)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          instr_valid,
    input  logic          NotAnInstr,
    input  logic          ERet,
    input  logic [3:0]    EStatus_in,
    input  logic [N-1:0]  pc_in,
    input  logic          IRQ_req,
    output logic          IRQ_ack,
    output logic          exc,
    output logic [N-1:0]  exc_vector,
    output logic          eret_taken,
    output logic [N-1:0]  ERR,
    output logic [3:0]    ESR,
    output logic          in_handler,
    output logic [15:0]   exc_count
);

    typedef enum logic {
        IDLE,
        HANDLER
    } state_t;

    localparam logic [3:0] ESR_IRQ          = 4'b0001;
    localparam logic [3:0] ESR_DOUBLE_FAULT = 4'b1000;

    state_t state;
    logic   irq_armed;
    logic   bad_instr;
    logic   eret_instr;

    // A bubble must never raise an exception or return from one.
    assign bad_instr  = instr_valid && NotAnInstr;
    assign eret_instr = instr_valid && ERet;
    assign exc_vector = EXC_VECTOR;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ERR        <= '0;
            ESR        <= '0;
            exc        <= 1'b0;
            eret_taken <= 1'b0;
            IRQ_ack    <= 1'b0;
            in_handler <= 1'b0;
            irq_armed  <= 1'b1;
        end else begin
            exc        <= 1'b0;
            eret_taken <= 1'b0;
            IRQ_ack    <= 1'b0;
            // Re-arm only once the requester has visibly dropped its request.
            if (!IRQ_req)
                irq_armed <= 1'b1;

            case (state)
                IDLE: begin
                    if (bad_instr) begin
                        ERR        <= pc_in;
                        ESR        <= EStatus_in;
                        exc        <= 1'b1;
                        state      <= HANDLER;
                        in_handler <= 1'b1;
                    end else if (IRQ_req && irq_armed) begin
                        ERR        <= pc_in;
                        ESR        <= ESR_IRQ;
                        exc        <= 1'b1;
                        IRQ_ack    <= 1'b1;
                        irq_armed  <= 1'b0;
                        state      <= HANDLER;
                        in_handler <= 1'b1;
                    end
                end
                HANDLER: begin
                    // Interrupts are masked here; a fault keeps the original return address.
                    if (bad_instr) begin
                        ESR <= ESR_DOUBLE_FAULT;
                        exc <= 1'b1;
                    end else if (eret_instr) begin
                        eret_taken <= 1'b1;
                        state      <= IDLE;
                        in_handler <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    in_handler <= 1'b0;
                end
            endcase
        end
    end

`ifdef EXC_COUNTER_EN
    logic take_exc;
    assign take_exc = bad_instr || (state == IDLE && IRQ_req && irq_armed);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            exc_count <= '0;
        else if (take_exc && exc_count != 16'hFFFF)
            exc_count <= exc_count + 16'd1;
    end
`else
    assign exc_count = 16'h0000;
`endif

endmodule

// File: tb/tb_exception_ctrl.sv
// Scoreboard bench for exception_ctrl: stimulus queues expected pulse responses,
// a negedge monitor pops and compares them; direct checks cover quiet cycles and reset.
module tb_exception_ctrl;

    localparam int N = 64;

    typedef struct {
        logic          exc;
        logic          eret;
        logic          ack;
        logic [N-1:0]  err;
        logic [3:0]    esr;
        logic          inh;
        logic [15:0]   cnt;
    } resp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          instr_valid = 1'b0;
    logic          NotAnInstr = 1'b0;
    logic          ERet = 1'b0;
    logic [3:0]    EStatus_in = 4'h0;
    logic [N-1:0]  pc_in = '0;
    logic          IRQ_req = 1'b0;
    logic          IRQ_ack;
    logic          exc;
    logic [N-1:0]  exc_vector;
    logic          eret_taken;
    logic [N-1:0]  ERR;
    logic [3:0]    ESR;
    logic          in_handler;
    logic [15:0]   exc_count;

    int checks = 0;
    int failures = 0;
    resp_t exp_q[$];

    exception_ctrl #(.N(N)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .NotAnInstr(NotAnInstr),
        .ERet(ERet), .EStatus_in(EStatus_in), .pc_in(pc_in), .IRQ_req(IRQ_req),
        .IRQ_ack(IRQ_ack), .exc(exc), .exc_vector(exc_vector), .eret_taken(eret_taken),
        .ERR(ERR), .ESR(ESR), .in_handler(in_handler), .exc_count(exc_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] cnt_exp(input int n);
`ifdef EXC_COUNTER_EN
        return 16'(n);
`else
        return 16'(0 * n);
`endif
    endfunction

    task automatic drive(input logic v, input logic nai, input logic er,
                         input logic [3:0] es, input logic [N-1:0] pc, input logic irq);
        instr_valid = v;
        NotAnInstr  = nai;
        ERet        = er;
        EStatus_in  = es;
        pc_in       = pc;
        IRQ_req     = irq;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_resp(input logic e, input logic r, input logic a, input logic [N-1:0] err,
                               input logic [3:0] esr, input logic inh, input int n);
        resp_t t;
        t.exc = e; t.eret = r; t.ack = a; t.err = err; t.esr = esr; t.inh = inh; t.cnt = cnt_exp(n);
        exp_q.push_back(t);
    endtask

    task automatic check_quiet(input string name, input logic [N-1:0] err, input logic [3:0] esr,
                               input logic inh);
        check({name, ".exc"}, 64'(exc), 64'd0);
        check({name, ".eret"}, 64'(eret_taken), 64'd0);
        check({name, ".ack"}, 64'(IRQ_ack), 64'd0);
        check({name, ".ERR"}, ERR, err);
        check({name, ".ESR"}, 64'(ESR), 64'(esr));
        check({name, ".in_handler"}, 64'(in_handler), 64'(inh));
    endtask

    task automatic check_reset_vals(input string name);
        check_quiet(name, '0, 4'h0, 1'b0);
        check({name, ".exc_count"}, 64'(exc_count), 64'd0);
    endtask

    // Monitor: every exc or eret_taken pulse must match the next queued response.
    always @(negedge clk) begin
        if (!reset && (exc || eret_taken)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse: exc=%0b eret=%0b with empty scoreboard (t=%0t)",
                         exc, eret_taken, $time);
            end else begin
                resp_t t;
                t = exp_q.pop_front();
                check("mon.exc", 64'(exc), 64'(t.exc));
                check("mon.eret", 64'(eret_taken), 64'(t.eret));
                check("mon.ack", 64'(IRQ_ack), 64'(t.ack));
                check("mon.ERR", ERR, t.err);
                check("mon.ESR", 64'(ESR), 64'(t.esr));
                check("mon.in_handler", 64'(in_handler), 64'(t.inh));
                check("mon.exc_count", 64'(exc_count), 64'(t.cnt));
            end
        end
    end

    initial begin
        #12;
        check_reset_vals("reset");
        check("exc_vector", exc_vector, 64'h0000_0000_0000_00D8);
        tick();
        reset = 1'b0;
        tick();

        // Invalid opcode in IDLE
        drive(1, 1, 0, 4'b0010, 64'h40, 0);
        expect_resp(1, 0, 0, 64'h40, 4'b0010, 1, 1);
        tick();
        drive(0, 0, 0, 4'h0, 64'h0, 0);
        tick();
        check_quiet("after_bad_op", 64'h40, 4'b0010, 1);

        drive(1, 0, 1, 4'h0, 64'h44, 0);
        expect_resp(0, 1, 0, 64'h40, 4'b0010, 0, 1);
        tick();
        drive(0, 0, 0, 4'h0, 64'h0, 0);
        tick();

        // IRQ in IDLE, held high through the following ERET
        drive(0, 0, 0, 4'h0, 64'h100, 1);
        expect_resp(1, 0, 1, 64'h100, 4'b0001, 1, 2);
        tick();
        drive(0, 0, 0, 4'h0, 64'h104, 1);
        tick();
        check_quiet("irq_ack_one_cycle", 64'h100, 4'b0001, 1);
        drive(1, 0, 1, 4'h0, 64'h108, 1);
        expect_resp(0, 1, 0, 64'h100, 4'b0001, 0, 2);
        tick();
        drive(0, 0, 0, 4'h0, 64'h10C, 1);
        tick();
        tick();
        check_quiet("irq_held_no_retake", 64'h100, 4'b0001, 0);

        // Drop then raise: exactly one new exc/ack pair
        drive(0, 0, 0, 4'h0, 64'h110, 0);
        tick();
        drive(0, 0, 0, 4'h0, 64'h200, 1);
        expect_resp(1, 0, 1, 64'h200, 4'b0001, 1, 3);
        tick();
        drive(0, 0, 0, 4'h0, 64'h204, 0);
        tick();
        check_quiet("second_irq_single", 64'h200, 4'b0001, 1);

        // Double fault with ERet in HANDLER: fault wins, ERR kept
        drive(1, 1, 1, 4'b0010, 64'h300, 0);
        expect_resp(1, 0, 0, 64'h200, 4'b1000, 1, 4);
        tick();
        drive(0, 0, 0, 4'h0, 64'h0, 0);
        tick();

        // Bubbles in HANDLER
        drive(0, 1, 1, 4'b0011, 64'h500, 0);
        tick();
        tick();
        check_quiet("bubble_handler", 64'h200, 4'b1000, 1);

        // IRQ masked in HANDLER, taken on first IDLE cycle after ERET
        drive(0, 0, 0, 4'h0, 64'h600, 1);
        tick();
        tick();
        check_quiet("irq_masked", 64'h200, 4'b1000, 1);
        drive(1, 0, 1, 4'h0, 64'h600, 1);
        expect_resp(0, 1, 0, 64'h200, 4'b1000, 0, 4);
        expect_resp(1, 0, 1, 64'h600, 4'b0001, 1, 5);
        tick();
        drive(0, 0, 0, 4'h0, 64'h600, 1);
        tick();
        drive(0, 0, 0, 4'h0, 64'h0, 0);
        tick();
        drive(1, 0, 1, 4'h0, 64'h0, 0);
        expect_resp(0, 1, 0, 64'h600, 4'b0001, 0, 5);
        tick();
        drive(0, 0, 0, 4'h0, 64'h0, 0);
        tick();

        // Bubbles and valid ERET in IDLE are ignored
        drive(0, 1, 1, 4'b0111, 64'h700, 0);
        tick();
        tick();
        check_quiet("bubble_idle", 64'h600, 4'b0001, 0);
        drive(1, 0, 1, 4'b0111, 64'h704, 0);
        tick();
        drive(0, 0, 0, 4'h0, 64'h0, 0);
        tick();
        check_quiet("eret_idle_ignored", 64'h600, 4'b0001, 0);

        // Enter handler, then reset asynchronously while a pulse is pending
        drive(1, 1, 0, 4'b0010, 64'h800, 0);
        expect_resp(1, 0, 0, 64'h800, 4'b0010, 1, 6);
        tick();
        drive(0, 0, 0, 4'h0, 64'h0, 0);
        tick();
        check("count_before_reset", 64'(exc_count), 64'(cnt_exp(6)));
        drive(1, 1, 0, 4'h0, 64'h900, 0);
        tick();
        check("pending_pulse", 64'(exc), 64'd1);
        drive(0, 0, 0, 4'h0, 64'h0, 0);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("async_reset");
        tick();
        tick();
        check_reset_vals("held_reset");
        reset = 1'b0;
        tick();

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
